// File: rtl/rv32i_decode.sv
// RV32I instruction decoder.
// Splits an instruction word into opcode/funct/register fields, builds the
// sign-extended immediate for the instruction format, flags illegal encodings
// and keeps a sticky illegal-instruction flag.
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   dec_en        : decode strobe (qualifies sticky flag and registered capture)
//   insn          : 32-bit instruction word
//   opcode        : insn[6:2]
//   funct7/funct3 : insn[31:25] / insn[14:12]
//   rd/rs1/rs2    : insn[11:7] / insn[19:15] / insn[24:20]
//   imm           : sign-extended immediate (0 for R-type and unknown opcodes)
//   invalid       : current decode is illegal
//   invalid_seen  : sticky, set when an illegal insn is decoded with dec_en=1
// REG_OUT=0 makes the decode outputs combinational; REG_OUT=1 registers them
// on clk when dec_en=1.
module rv32i_decode #(
  parameter bit REG_OUT = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        dec_en,
  input  logic [31:0] insn,
  output logic [4:0]  opcode,
  output logic [6:0]  funct7,
  output logic [2:0]  funct3,
  output logic        invalid,
  output logic [4:0]  rd,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [31:0] imm,
  output logic        invalid_seen
);

  localparam int unsigned XLEN = 32;

  localparam logic [4:0] OP_LOAD   = 5'b00000;
  localparam logic [4:0] OP_MISC   = 5'b00011;
  localparam logic [4:0] OP_ALUIMM = 5'b00100;
  localparam logic [4:0] OP_AUIPC  = 5'b00101;
  localparam logic [4:0] OP_STORE  = 5'b01000;
  localparam logic [4:0] OP_ALU    = 5'b01100;
  localparam logic [4:0] OP_LUI    = 5'b01101;
  localparam logic [4:0] OP_BRANCH = 5'b11000;
  localparam logic [4:0] OP_JALR   = 5'b11001;
  localparam logic [4:0] OP_JAL    = 5'b11011;
  localparam logic [4:0] OP_SYSTEM = 5'b11100;

  localparam logic [6:0] F7_ZERO = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  logic [4:0]      dec_op;
  logic [2:0]      dec_f3;
  logic [6:0]      dec_f7;
  logic [XLEN-1:0] dec_imm;
  logic            dec_invalid;

  assign dec_op = insn[6:2];
  assign dec_f3 = insn[14:12];
  assign dec_f7 = insn[31:25];

  // Immediate assembly and legality check per opcode
  always_comb begin
    dec_imm     = '0;
    dec_invalid = 1'b0;
    case (dec_op)
      OP_LOAD: begin
        dec_imm = {{20{insn[31]}}, insn[31:20]};
        if (dec_f3 == 3'b011 || dec_f3[2:1] == 2'b11) dec_invalid = 1'b1;
      end
      OP_MISC, OP_SYSTEM: begin
        dec_imm = {{20{insn[31]}}, insn[31:20]};
      end
      OP_ALUIMM: begin
        dec_imm = {{20{insn[31]}}, insn[31:20]};
        // Shift-immediates reuse funct7 as the upper immediate bits
        if (dec_f3 == 3'b001 && dec_f7 != F7_ZERO) dec_invalid = 1'b1;
        if (dec_f3 == 3'b101 && dec_f7 != F7_ZERO && dec_f7 != F7_ALT) dec_invalid = 1'b1;
      end
      OP_JALR: begin
        dec_imm = {{20{insn[31]}}, insn[31:20]};
        if (dec_f3 != 3'b000) dec_invalid = 1'b1;
      end
      OP_AUIPC, OP_LUI: begin
        dec_imm = {insn[31:12], 12'b0};
      end
      OP_STORE: begin
        dec_imm = {{20{insn[31]}}, insn[31:25], insn[11:7]};
        if (dec_f3 > 3'b010) dec_invalid = 1'b1;
      end
      OP_ALU: begin
        if (dec_f7 != F7_ZERO && dec_f7 != F7_ALT) dec_invalid = 1'b1;
        if (dec_f7 == F7_ALT && dec_f3 != 3'b000 && dec_f3 != 3'b101) dec_invalid = 1'b1;
      end
      OP_BRANCH: begin
        dec_imm = {{20{insn[31]}}, insn[7], insn[30:25], insn[11:8], 1'b0};
        if (dec_f3[2:1] == 2'b01) dec_invalid = 1'b1;
      end
      OP_JAL: begin
        dec_imm = {{12{insn[31]}}, insn[19:12], insn[20], insn[30:21], 1'b0};
      end
      default: begin
        dec_invalid = 1'b1;
      end
    endcase
    if (insn[1:0] != 2'b11) dec_invalid = 1'b1;
  end

  generate
    if (REG_OUT) begin : g_reg
      // Capture decode on strobe; hold otherwise
      always_ff @(posedge clk) begin
        if (rst) begin
          opcode  <= '0;
          funct7  <= '0;
          funct3  <= '0;
          rd      <= '0;
          rs1     <= '0;
          rs2     <= '0;
          imm     <= '0;
          invalid <= 1'b0;
        end else if (dec_en) begin
          opcode  <= dec_op;
          funct7  <= dec_f7;
          funct3  <= dec_f3;
          rd      <= insn[11:7];
          rs1     <= insn[19:15];
          rs2     <= insn[24:20];
          imm     <= dec_imm;
          invalid <= dec_invalid;
        end
      end
    end else begin : g_comb
      assign opcode  = dec_op;
      assign funct7  = dec_f7;
      assign funct3  = dec_f3;
      assign rd      = insn[11:7];
      assign rs1     = insn[19:15];
      assign rs2     = insn[24:20];
      assign imm     = dec_imm;
      assign invalid = dec_invalid;
    end
  endgenerate

  // Sticky illegal flag; reset wins over a same-edge set
  always_ff @(posedge clk) begin
    if (rst) begin
      invalid_seen <= 1'b0;
    end else if (dec_en && dec_invalid) begin
      invalid_seen <= 1'b1;
    end
  end

endmodule

// File: tb/tb_rv32i_decode.sv
// Directed bench for rv32i_decode: one combinational instance (REG_OUT=0)
// and one registered instance (REG_OUT=1) share the same stimulus.
module tb_rv32i_decode;

  logic        clk;
  logic        rst;
  logic        dec_en;
  logic [31:0] insn;

  logic [4:0]  c_opcode, r_opcode;
  logic [6:0]  c_funct7, r_funct7;
  logic [2:0]  c_funct3, r_funct3;
  logic        c_invalid, r_invalid;
  logic [4:0]  c_rd, r_rd, c_rs1, r_rs1, c_rs2, r_rs2;
  logic [31:0] c_imm, r_imm;
  logic        c_seen, r_seen;

  int errors = 0;
  int checks = 0;

  rv32i_decode #(.REG_OUT(1'b0)) u_comb (
    .clk(clk), .rst(rst), .dec_en(dec_en), .insn(insn),
    .opcode(c_opcode), .funct7(c_funct7), .funct3(c_funct3),
    .invalid(c_invalid), .rd(c_rd), .rs1(c_rs1), .rs2(c_rs2),
    .imm(c_imm), .invalid_seen(c_seen)
  );

  rv32i_decode #(.REG_OUT(1'b1)) u_reg (
    .clk(clk), .rst(rst), .dec_en(dec_en), .insn(insn),
    .opcode(r_opcode), .funct7(r_funct7), .funct3(r_funct3),
    .invalid(r_invalid), .rd(r_rd), .rs1(r_rs1), .rs2(r_rs2),
    .imm(r_imm), .invalid_seen(r_seen)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; dec_en = 1'b0; insn = 32'h0;
    tick(); tick();
    checks++;
    if (c_seen !== 1'b0 || r_seen !== 1'b0) begin
      errors++; $display("FAIL reset_seen got c=%b r=%b want 0", c_seen, r_seen);
    end
    checks++;
    if ({r_opcode, r_funct7, r_funct3, r_rd, r_rs1, r_rs2, r_imm, r_invalid} !== '0) begin
      errors++; $display("FAIL reset_regout got op=%b imm=%h inv=%b want all 0", r_opcode, r_imm, r_invalid);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_fields();
    insn = 32'hFFF10093; #1;
    checks++;
    if (c_opcode !== 5'b00100 || c_rd !== 5'd1 || c_rs1 !== 5'd2 || c_funct3 !== 3'd0 ||
        c_rs2 !== 5'd31 || c_funct7 !== 7'h7F || c_imm !== 32'hFFFFFFFF || c_invalid !== 1'b0) begin
      errors++; $display("FAIL addi got op=%b rd=%0d rs1=%0d f3=%0d rs2=%0d f7=%h imm=%h inv=%b",
                         c_opcode, c_rd, c_rs1, c_funct3, c_rs2, c_funct7, c_imm, c_invalid);
    end
    insn = 32'h00552423; #1;
    checks++;
    if (c_opcode !== 5'b01000 || c_rs1 !== 5'd10 || c_rs2 !== 5'd5 || c_funct3 !== 3'b010 ||
        c_rd !== 5'd8 || c_imm !== 32'h8 || c_invalid !== 1'b0) begin
      errors++; $display("FAIL sw got op=%b rs1=%0d rs2=%0d f3=%b rd=%0d imm=%h inv=%b",
                         c_opcode, c_rs1, c_rs2, c_funct3, c_rd, c_imm, c_invalid);
    end
  endtask

  task automatic test_imm();
    logic [31:0] vin  [7] = '{32'hFE000EE3, 32'h123451B7, 32'h001000EF, 32'h40005013,
                              32'h40000033, 32'hFFFFF073, 32'h0000007F};
    logic [31:0] vimm [7] = '{32'hFFFFFFFC, 32'h12345000, 32'h00000800, 32'h00000400,
                              32'h00000000, 32'hFFFFFFFF, 32'h00000000};
    logic [4:0]  vop  [7] = '{5'b11000, 5'b01101, 5'b11011, 5'b00100,
                              5'b01100, 5'b11100, 5'b11111};
    for (int i = 0; i < 7; i++) begin
      insn = vin[i]; #1;
      checks++;
      if (c_imm !== vimm[i] || c_opcode !== vop[i]) begin
        errors++; $display("FAIL imm[%0d] insn=%h got imm=%h op=%b want imm=%h op=%b",
                           i, vin[i], c_imm, c_opcode, vimm[i], vop[i]);
      end
    end
    insn = 32'h123451B7; #1;
    checks++;
    if (c_rd !== 5'd3) begin
      errors++; $display("FAIL lui_rd got %0d want 3", c_rd);
    end
  endtask

  task automatic test_invalid();
    logic [31:0] vin [16] = '{32'h00000000, 32'h0000007F, 32'h00002063, 32'h00003003,
                              32'h00006003, 32'h00002003, 32'h00003023, 32'h00002023,
                              32'h00001067, 32'h00000067, 32'h02000033, 32'h40001033,
                              32'h40005033, 32'h40001013, 32'h40005013, 32'h00000073};
    logic        vinv [16] = '{1'b1, 1'b1, 1'b1, 1'b1,
                               1'b1, 1'b0, 1'b1, 1'b0,
                               1'b1, 1'b0, 1'b1, 1'b1,
                               1'b0, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 16; i++) begin
      insn = vin[i]; #1;
      checks++;
      if (c_invalid !== vinv[i]) begin
        errors++; $display("FAIL invalid[%0d] insn=%h got %b want %b", i, vin[i], c_invalid, vinv[i]);
      end
    end
  endtask

  task automatic test_sticky();
    rst = 1'b1; tick(); rst = 1'b0;
    insn = 32'h00000000; dec_en = 1'b0; tick();
    checks++;
    if (c_seen !== 1'b0) begin
      errors++; $display("FAIL sticky_no_en got %b want 0", c_seen);
    end
    dec_en = 1'b1; tick();
    checks++;
    if (c_seen !== 1'b1) begin
      errors++; $display("FAIL sticky_set got %b want 1", c_seen);
    end
    insn = 32'hFFF10093; tick(); insn = 32'h00552423; tick();
    checks++;
    if (c_seen !== 1'b1) begin
      errors++; $display("FAIL sticky_hold got %b want 1", c_seen);
    end
    insn = 32'h00000000; rst = 1'b1; tick();
    checks++;
    if (c_seen !== 1'b0) begin
      errors++; $display("FAIL sticky_rst_priority got %b want 0", c_seen);
    end
    rst = 1'b0; insn = 32'hFFF10093; tick();
    checks++;
    if (c_seen !== 1'b0) begin
      errors++; $display("FAIL sticky_after_rst got %b want 0", c_seen);
    end
    dec_en = 1'b0;
  endtask

  task automatic test_registered();
    rst = 1'b1; tick(); rst = 1'b0;
    insn = 32'hFFF10093; dec_en = 1'b1; #1;
    checks++;
    if (r_imm !== 32'h0) begin
      errors++; $display("FAIL reg_latency got imm=%h want 00000000", r_imm);
    end
    tick();
    checks++;
    if (r_imm !== 32'hFFFFFFFF || r_opcode !== 5'b00100 || r_rd !== 5'd1 || r_rs1 !== 5'd2 || r_invalid !== 1'b0) begin
      errors++; $display("FAIL reg_capture got imm=%h op=%b rd=%0d rs1=%0d inv=%b", r_imm, r_opcode, r_rd, r_rs1, r_invalid);
    end
    dec_en = 1'b0; insn = 32'h00552423; tick(); tick();
    checks++;
    if (r_imm !== 32'hFFFFFFFF || r_opcode !== 5'b00100 || r_rd !== 5'd1) begin
      errors++; $display("FAIL reg_hold got imm=%h op=%b rd=%0d", r_imm, r_opcode, r_rd);
    end
    dec_en = 1'b1; insn = 32'h00000000; tick();
    checks++;
    if (r_invalid !== 1'b1 || r_seen !== 1'b1) begin
      errors++; $display("FAIL reg_invalid got inv=%b seen=%b want 1 1", r_invalid, r_seen);
    end
    insn = 32'hFE000EE3; tick();
    checks++;
    if (r_imm !== 32'hFFFFFFFC || r_invalid !== 1'b0) begin
      errors++; $display("FAIL reg_branch got imm=%h inv=%b", r_imm, r_invalid);
    end
    rst = 1'b1; tick();
    checks++;
    if ({r_opcode, r_funct7, r_funct3, r_rd, r_rs1, r_rs2, r_imm, r_invalid, r_seen} !== '0) begin
      errors++; $display("FAIL reg_rst got op=%b f7=%h imm=%h inv=%b seen=%b want all 0",
                         r_opcode, r_funct7, r_imm, r_invalid, r_seen);
    end
    rst = 1'b0; insn = 32'h123451B7; tick();
    checks++;
    if (r_imm !== 32'h12345000 || r_rd !== 5'd3) begin
      errors++; $display("FAIL reg_resume got imm=%h rd=%0d", r_imm, r_rd);
    end
    dec_en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_fields();
    test_imm();
    test_invalid();
    test_sticky();
    test_registered();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
